// File: rtl/sort_vis_pkg.sv
// ---------------------------------------------------------------------------
// sort_vis_pkg
// Shared definitions for the sort visualiser: the bubble-sort engine state
// encoding, default array geometry and the bar colours the OLED renderer
// uses to highlight the engine's activity.
// Ports: none (package).
// ---------------------------------------------------------------------------
package sort_vis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_SWAP = 2'd2,
        ST_DONE = 2'd3
    } sort_state_t;

    // Default geometry: 5 bars, 7-bit heights, saturate one below 64 rows.
    localparam int DEF_N_BARS     = 5;
    localparam int DEF_HEIGHT_W   = 7;
    localparam int DEF_MAX_HEIGHT = 63;

    // RGB565 bar colours shared with the pixel-colour stage.
    localparam logic [15:0] COL_BACKGROUND = 16'h0000;
    localparam logic [15:0] COL_BAR_IDLE   = 16'hFFFF;
    localparam logic [15:0] COL_BAR_CMP    = 16'hFFE0;
    localparam logic [15:0] COL_BAR_SWAP   = 16'hF800;
    localparam logic [15:0] COL_BAR_DONE   = 16'h07E0;

endpackage

// File: rtl/bubble_sort_engine_if.sv
// ---------------------------------------------------------------------------
// bubble_sort_engine_if
// Control/data bundle between the switch/tick logic, the sort engine and
// the renderer.
//   master : drives step, load, start, heights_in; observes engine status
//   slave  : the engine (inverse directions)
// Signals:
//   step        advance strobe          load/heights_in  capture new array
//   start       begin sorting           heights_out      current array
//   cmp_idx     left index of pair      cmp_valid        pair is active
//   swapped     pulse after a swap      pass_cnt         completed passes
//   busy        sorting                 done             sort finished
// ---------------------------------------------------------------------------
interface bubble_sort_engine_if
    import sort_vis_pkg::*;
#(
    parameter int N_BARS   = DEF_N_BARS,
    parameter int HEIGHT_W = DEF_HEIGHT_W
);

    logic                         step;
    logic                         load;
    logic                         start;
    logic [N_BARS*HEIGHT_W-1:0]   heights_in;
    logic [N_BARS*HEIGHT_W-1:0]   heights_out;
    logic [2:0]                   cmp_idx;
    logic                         cmp_valid;
    logic                         swapped;
    logic [2:0]                   pass_cnt;
    logic                         busy;
    logic                         done;

    modport master (
        output step, load, start, heights_in,
        input  heights_out, cmp_idx, cmp_valid, swapped, pass_cnt, busy, done
    );

    modport slave (
        input  step, load, start, heights_in,
        output heights_out, cmp_idx, cmp_valid, swapped, pass_cnt, busy, done
    );

endinterface

// File: rtl/sort_cmp_swap.sv
// ---------------------------------------------------------------------------
// sort_cmp_swap
// Holds the bar-height array and performs a registered compare-and-exchange
// of the pair (idx, idx+1). Heights are saturated to MAX_HEIGHT on load.
// Ports:
//   clk, reset   clock, synchronous active-high reset (clears the array)
//   load_en      capture heights_in (saturated)
//   heights_in   packed input array, bar i at [i*HEIGHT_W +: HEIGHT_W]
//   swap_en      exchange h[idx] and h[idx+1]
//   idx          left index of the active pair
//   heights_out  packed current array
//   gt           h[idx] > h[idx+1] (unsigned, strict)
// ---------------------------------------------------------------------------
module sort_cmp_swap
    import sort_vis_pkg::*;
#(
    parameter int N_BARS     = DEF_N_BARS,
    parameter int HEIGHT_W   = DEF_HEIGHT_W,
    parameter int MAX_HEIGHT = DEF_MAX_HEIGHT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_en,
    input  logic [N_BARS*HEIGHT_W-1:0] heights_in,
    input  logic                       swap_en,
    input  logic [2:0]                 idx,
    output logic [N_BARS*HEIGHT_W-1:0] heights_out,
    output logic                       gt
);

    logic [HEIGHT_W-1:0] h_q [N_BARS];

    function automatic logic [HEIGHT_W-1:0] saturate(input logic [HEIGHT_W-1:0] v);
        return (int'(v) > MAX_HEIGHT) ? HEIGHT_W'(MAX_HEIGHT) : v;
    endfunction

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise an unmatched idx would infer a latch.
    always_comb begin
        gt = 1'b0;
        for (int i = 0; i < N_BARS - 1; i++) begin
            if (idx == 3'(i)) begin
                gt = (h_q[i] > h_q[i+1]);
            end
        end
    end

    // NOTE: the array is reset on purpose (the display must show empty bars
    // after reset); the non-blocking exchange reads both old values, so no
    // temporary is needed for the swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_BARS; i++) begin
                h_q[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < N_BARS; i++) begin
                h_q[i] <= saturate(heights_in[i*HEIGHT_W +: HEIGHT_W]);
            end
        end else if (swap_en) begin
            for (int i = 0; i < N_BARS - 1; i++) begin
                if (idx == 3'(i)) begin
                    h_q[i]   <= h_q[i+1];
                    h_q[i+1] <= h_q[i];
                end
            end
        end
    end

    always_comb begin
        heights_out = '0;
        for (int i = 0; i < N_BARS; i++) begin
            heights_out[i*HEIGHT_W +: HEIGHT_W] = h_q[i];
        end
    end

endmodule

// File: rtl/bubble_sort_engine.sv
// ---------------------------------------------------------------------------
// bubble_sort_engine
// Step-by-step bubble sort of N_BARS bar heights for the animated bar chart.
// Each step pulse performs one compare (CMP) or one exchange (SWAP); the
// active pair index and a swap strobe are exported for highlighting.
// Ports:
//   clk    100 MHz system clock
//   reset  synchronous active-high reset
//   bus    bubble_sort_engine_if.slave (step/load/start/heights_in in;
//          heights_out/cmp_idx/cmp_valid/swapped/pass_cnt/busy/done out)
// Build option:
//   BUBBLE_EARLY_EXIT_EN  finish as soon as a complete pass makes no swap
//                         (pass_cnt still counts that final pass).
// ---------------------------------------------------------------------------
module bubble_sort_engine
    import sort_vis_pkg::*;
#(
    parameter int N_BARS     = DEF_N_BARS,
    parameter int HEIGHT_W   = DEF_HEIGHT_W,
    parameter int MAX_HEIGHT = DEF_MAX_HEIGHT
) (
    input  logic                 clk,
    input  logic                 reset,
    bubble_sort_engine_if.slave  bus
);

    localparam logic [2:0] LAST_PASS = 3'(N_BARS - 1);

    sort_state_t state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  pass_q, pass_d;
    logic        swapped_q, swapped_d;
    logic        active_q;
    logic        done_q;
    logic        load_en;
    logic        swap_en;
    logic        advance;
    logic        gt;

`ifdef BUBBLE_EARLY_EXIT_EN
    logic        flag_q, flag_d;     // a swap happened in the current pass
    logic        pass_had_swap;
`endif

    sort_cmp_swap #(
        .N_BARS     (N_BARS),
        .HEIGHT_W   (HEIGHT_W),
        .MAX_HEIGHT (MAX_HEIGHT)
    ) u_cmp_swap (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .heights_in  (bus.heights_in),
        .swap_en     (swap_en),
        .idx         (idx_q),
        .heights_out (bus.heights_out),
        .gt          (gt)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        swapped_d = 1'b0;
        load_en   = 1'b0;
        swap_en   = 1'b0;
        advance   = 1'b0;
`ifdef BUBBLE_EARLY_EXIT_EN
        flag_d        = flag_q;
        pass_had_swap = flag_q;
`endif

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // load has priority over a simultaneous start
                if (bus.load) begin
                    load_en = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    idx_d   = '0;
                    pass_d  = '0;
                    state_d = ST_CMP;
`ifdef BUBBLE_EARLY_EXIT_EN
                    flag_d  = 1'b0;
`endif
                end
            end
            ST_CMP: begin
                if (bus.step) begin
                    if (gt) begin
                        state_d = ST_SWAP;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_SWAP: begin
                if (bus.step) begin
                    swap_en   = 1'b1;
                    swapped_d = 1'b1;
                    advance   = 1'b1;
`ifdef BUBBLE_EARLY_EXIT_EN
                    flag_d        = 1'b1;
                    pass_had_swap = 1'b1;
`endif
                end
            end
            default: ;
        endcase

        // Each pass p covers pairs 0 .. N_BARS-2-p; the tail is already final.
        if (advance) begin
            if (int'(idx_q) < N_BARS - 2 - int'(pass_q)) begin
                idx_d   = idx_q + 3'd1;
                state_d = ST_CMP;
            end else begin
                idx_d  = '0;
                pass_d = pass_q + 3'd1;
`ifdef BUBBLE_EARLY_EXIT_EN
                flag_d  = 1'b0;
                state_d = (pass_d == LAST_PASS || !pass_had_swap) ? ST_DONE : ST_CMP;
`else
                state_d = (pass_d == LAST_PASS) ? ST_DONE : ST_CMP;
`endif
            end
        end
    end

    // Status flags are registered from the next state so that every output
    // comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef BUBBLE_EARLY_EXIT_EN
            flag_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
            active_q  <= (state_d == ST_CMP) || (state_d == ST_SWAP);
            done_q    <= (state_d == ST_DONE);
`ifdef BUBBLE_EARLY_EXIT_EN
            flag_q    <= flag_d;
`endif
        end
    end

    assign bus.cmp_idx   = idx_q;
    assign bus.cmp_valid = active_q;
    assign bus.busy      = active_q;
    assign bus.swapped   = swapped_q;
    assign bus.pass_cnt  = pass_q;
    assign bus.done      = done_q;

endmodule

// File: doc/bubble_sort_engine.md
# bubble_sort_engine

Sequential, step-by-step bubble sort engine that feeds the bar-chart OLED renderer. It holds the bar heights and performs one compare or one swap per `step` pulse, so the renderer can animate the sort. It also exposes the active comparison index and a swap strobe, which the renderer uses for highlighting. It sits between the switch/tick logic and the pixel-colour stage, in the 100 MHz `clk` domain.

## Interface
- `N_BARS`, default 5: number of bars, range 2..8.
- `HEIGHT_W`, default 7: width of each height in bits.
- `MAX_HEIGHT`, default 63: saturation value, one less than the display row count.
- `clk`, in, 1: system clock. The block uses one clock only.
- `reset`, in, 1: reset. It is synchronous and active-high.
- `step`, in, 1: single-cycle advance strobe from the animation tick divider.
- `load`, in, 1: captures `heights_in`.
- `heights_in`, in, N_BARS*HEIGHT_W: bar i occupies bits `[i*HEIGHT_W +: HEIGHT_W]`.
- `start`, in, 1: begins a sort of the held heights.
- `heights_out`, out, N_BARS*HEIGHT_W: current array, using the same packing as `heights_in`.
- `cmp_idx`, out, 3: left index of the active compare pair (i, i+1).
- `cmp_valid`, out, 1: high while a compare pair is active (CMP or SWAP state).
- `swapped`, out, 1: one-cycle pulse in the cycle after a swap is committed.
- `pass_cnt`, out, 3: number of completed passes.
- `busy`, out, 1: high in CMP or SWAP.
- `done`, out, 1: high in DONE. It stays high until the next `start` or `reset`.

## Operation
- **Reset values.** All outputs are 0. The heights array is 0 and the state is IDLE.
- **States:** IDLE, CMP, SWAP, DONE.
- **`load`** is accepted only in IDLE or DONE; it is ignored while `busy`.
  - Each height is saturated to MAX_HEIGHT on capture.
  - Load moves DONE back to IDLE and clears `done`.
- **`start`** is accepted in IDLE or DONE.
  - It sets i=0, `pass_cnt`=0 and clears the pass-swap flag, then enters CMP.
  - If `load` and `start` are asserted in the same cycle, load wins and start is ignored.
- **CMP**, on `step`:
  - If h[i] > h[i+1] (strict, so equal values never swap), go to SWAP.
  - Otherwise, advance.
- **SWAP**, on `step`:
  - Exchange h[i] and h[i+1], set the pass-swap flag, pulse `swapped`, then advance.
- **Advance:**
  - If i < N_BARS-2-`pass_cnt`: i ← i+1 and stay in or return to CMP.
  - Otherwise the pass ends: `pass_cnt`+1, i←0, clear the pass-swap flag.
  - If the new `pass_cnt` equals N_BARS-1, go to DONE; else go to CMP.
- `step` in IDLE or DONE has no effect.
- `start` while `busy` is ignored.
- Unsigned compare and arithmetic; `cmp_idx` and `pass_cnt` are zero-extended to 3 bits.

## Timing
- All outputs are registered.
- State and array updates are visible in the cycle after the `step`, `load` or `start` sample.
- `swapped` is high for exactly one cycle, aligned with the updated `heights_out`.
- In DONE, `cmp_valid` is 0 and `cmp_idx` is 0.
- `reset` mid-sort returns to IDLE with the array cleared on the next edge, regardless of `step`.
- Steps to DONE = compares + swaps.
- `step` is assumed at least 2 cycles apart. Back-to-back steps are still legal and are processed one per cycle.

## Configuration
- `BUBBLE_EARLY_EXIT_EN` defined:
  - At pass end, if the pass-swap flag is clear, go directly to DONE.
  - `pass_cnt` still increments for that final pass.
- `BUBBLE_EARLY_EXIT_EN` undefined:
  - Always run the full N_BARS-1 passes.
  - The pass-swap flag is not implemented.

## Structure
- Package `sort_vis_pkg` holds:
  - the state enum;
  - the N_BARS, HEIGHT_W and MAX_HEIGHT defaults;
  - the bar colour constants shared with the renderer.
- One sub-module, `sort_cmp_swap`, is natural: a registered compare-and-exchange of one indexed pair.
- The `step` tick divider stays outside this block.

## Test plan
- **Full sort.** Load [50,10,40,20,30], start, then issue steps.
  - Result: [10,20,30,40,50] with 6 `swapped` pulses.
  - `done` after 16 steps without EARLY_EXIT, or 15 steps with it.
- **Already sorted.** Load [10,20,30,40,50], start.
  - No `swapped` pulses.
  - `done` after 10 steps without early exit, or 4 steps (`pass_cnt`=1) with it.
- **Equal values.** Load [30,30,20,30,30].
  - Result: [20,30,30,30,30].
  - Equal pairs never pulse `swapped`; 2 swaps in total.
- **Saturation and load guard.**
  - Load [100,5,5,5,5]: `heights_out` bar 0 = 63.
  - `load` of a new array while `busy`: the array is unchanged.
  - `start` while `busy` is ignored.
- **Reset mid-sort.** Assert `reset` during SWAP.
  - Next cycle: all outputs 0 and state IDLE.
  - A later `step` has no effect until load and start.
- **Simultaneous load and start** in DONE.
  - The new array is captured, the state is IDLE, and `busy` stays 0.
